// File: rtl/sdram_sched_pkg.sv
// ---------------------------------------------------------------------------
// sdram_sched_pkg
// Shared definitions for the SDRAM stream scheduler:
//   - command type codes driven on cmd_type
//   - scheduler state encoding
//   - default geometry (word address width, burst length)
// ---------------------------------------------------------------------------
package sdram_sched_pkg;

  localparam int DEF_ADDR_W = 24;   // 2 bank + 13 row + 9 col
  localparam int DEF_BURST  = 256;  // words per read/write command

  localparam logic [1:0] CMD_WRITE   = 2'd0;
  localparam logic [1:0] CMD_READ    = 2'd1;
  localparam logic [1:0] CMD_REFRESH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/sdram_ring_ptr.sv
// ---------------------------------------------------------------------------
// sdram_ring_ptr
// Ring-buffer bookkeeping for the SDRAM: write pointer, read pointer and the
// number of words currently stored. Pointers advance by one burst per
// committed command and wrap modulo 2^ADDR_W.
// Ports:
//   CLK48M, RESET       clock, asynchronous active-low reset
//   commit_wr           a WRITE burst completed (advance wr_ptr, level up)
//   commit_rd           a READ burst completed (advance rd_ptr, level down)
//   wr_ptr, rd_ptr      next burst start addresses
//   level               stored words, 0 .. 2^ADDR_W
//   can_write           room for one more burst
//   can_read            at least one full burst stored
// ---------------------------------------------------------------------------
module sdram_ring_ptr
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int BURST  = DEF_BURST
) (
  input  logic              CLK48M,
  input  logic              RESET,
  input  logic              commit_wr,
  input  logic              commit_rd,
  output logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] rd_ptr,
  output logic [ADDR_W:0]   level,
  output logic              can_write,
  output logic              can_read
);

  localparam logic [ADDR_W-1:0] PTR_STEP   = ADDR_W'(BURST);
  localparam logic [ADDR_W:0]   LVL_STEP   = (ADDR_W+1)'(BURST);
  localparam logic [ADDR_W:0]   LVL_FULL   = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LVL_WR_MAX = LVL_FULL - LVL_STEP;

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;

  // Only one command is ever outstanding, so the two commits are exclusive
  // and level can neither overflow nor underflow given the can_* gating.
  always_ff @(posedge CLK48M or negedge RESET) begin
    if (!RESET) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (commit_wr) begin
      r_wr_ptr <= r_wr_ptr + PTR_STEP;
      r_level  <= r_level + LVL_STEP;
    end else if (commit_rd) begin
      r_rd_ptr <= r_rd_ptr + PTR_STEP;
      r_level  <= r_level - LVL_STEP;
    end
  end

  assign wr_ptr    = r_wr_ptr;
  assign rd_ptr    = r_rd_ptr;
  assign level     = r_level;
  assign can_write = (r_level <= LVL_WR_MAX);
  assign can_read  = (r_level >= LVL_STEP);

endmodule

// File: rtl/sdram_stream_scheduler.sv
// ---------------------------------------------------------------------------
// sdram_stream_scheduler
// Arbitrates the SDRAM controller's single command port between refresh,
// write bursts (generator FIFO -> SDRAM) and read bursts (SDRAM -> readback
// FIFO). SDRAM is used as a ring buffer tracked by sdram_ring_ptr.
// Ports:
//   CLK48M, RESET        clock, asynchronous active-low reset
//   enable               permits new write bursts
//   wr_usedw, wr_full    generator-side FIFO level / full flag
//   rd_free              free words in readback FIFO
//   ref_req              one-cycle refresh-due pulse
//   cmd_req/type/addr    command to controller, held until cmd_ack
//   cmd_ack, cmd_done    controller accept / completion pulses
//   level                words stored in SDRAM
//   busy                 scheduler not in IDLE
//   overflow, ref_miss   sticky error flags
// ---------------------------------------------------------------------------
module sdram_stream_scheduler
  import sdram_sched_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BURST     = DEF_BURST,
  parameter int FIFO_AW   = 10,
  parameter int WR_URGENT = 768
) (
  input  logic               CLK48M,
  input  logic               RESET,
  input  logic               enable,
  input  logic [FIFO_AW-1:0] wr_usedw,
  input  logic               wr_full,
  input  logic [FIFO_AW-1:0] rd_free,
  input  logic               ref_req,
  output logic               cmd_req,
  output logic [1:0]         cmd_type,
  output logic [ADDR_W-1:0]  cmd_addr,
  input  logic               cmd_ack,
  input  logic               cmd_done,
  output logic [ADDR_W:0]    level,
  output logic               busy,
  output logic               overflow,
  output logic               ref_miss
);

  localparam logic [FIFO_AW-1:0] BURST_F  = FIFO_AW'(BURST);
  localparam logic [FIFO_AW-1:0] URGENT_F = FIFO_AW'(WR_URGENT);

  state_t            r_state;
  logic              r_cmd_req;
  logic [1:0]        r_cmd_type;
  logic [ADDR_W-1:0] r_cmd_addr;
  logic              r_ref_pend;
  logic              r_ref_miss;
  logic              r_overflow;
  logic              r_last_wr;

  logic [ADDR_W-1:0] w_wr_ptr;
  logic [ADDR_W-1:0] w_rd_ptr;
  logic [ADDR_W:0]   w_level;
  logic              w_can_write;
  logic              w_can_read;
  logic              w_w_ok;
  logic              w_r_ok;
  logic              w_pick_wr;
  logic              w_ref_ack;
  logic              w_commit_wr;
  logic              w_commit_rd;

  sdram_ring_ptr #(
    .ADDR_W (ADDR_W),
    .BURST  (BURST)
  ) u_ring (
    .CLK48M    (CLK48M),
    .RESET     (RESET),
    .commit_wr (w_commit_wr),
    .commit_rd (w_commit_rd),
    .wr_ptr    (w_wr_ptr),
    .rd_ptr    (w_rd_ptr),
    .level     (w_level),
    .can_write (w_can_write),
    .can_read  (w_can_read)
  );

  assign w_w_ok = enable && (wr_usedw >= BURST_F) && w_can_write;
  assign w_r_ok = w_can_read && (rd_free >= BURST_F);

  // Urgent fill level forces a write; otherwise alternate when both are
  // eligible so neither direction starves.
  assign w_pick_wr = w_w_ok && ((wr_usedw >= URGENT_F) || !w_r_ok || !r_last_wr);

  assign w_ref_ack   = (r_state == ISSUE) && cmd_ack && (r_cmd_type == CMD_REFRESH);
  assign w_commit_wr = (r_state == WAIT) && cmd_done && (r_cmd_type == CMD_WRITE);
  assign w_commit_rd = (r_state == WAIT) && cmd_done && (r_cmd_type == CMD_READ);

  always_ff @(posedge CLK48M or negedge RESET) begin
    if (!RESET) begin
      r_state    <= IDLE;
      r_cmd_req  <= 1'b0;
      r_cmd_type <= CMD_WRITE;
      r_cmd_addr <= '0;
      r_ref_pend <= 1'b0;
      r_ref_miss <= 1'b0;
      r_overflow <= 1'b0;
      r_last_wr  <= 1'b0;
    end else begin
      if (ref_req && r_ref_pend)
        r_ref_miss <= 1'b1;
      // A new refresh request wins over clearing on acceptance.
      if (ref_req)
        r_ref_pend <= 1'b1;
      else if (w_ref_ack)
        r_ref_pend <= 1'b0;

      if (enable && wr_full)
        r_overflow <= 1'b1;

      case (r_state)
        IDLE: begin
          if (r_ref_pend) begin
            r_cmd_type <= CMD_REFRESH;
            r_cmd_addr <= '0;
            r_cmd_req  <= 1'b1;
            r_state    <= ISSUE;
          end else if (w_pick_wr) begin
            r_cmd_type <= CMD_WRITE;
            r_cmd_addr <= w_wr_ptr;
            r_cmd_req  <= 1'b1;
            r_state    <= ISSUE;
          end else if (w_r_ok) begin
            r_cmd_type <= CMD_READ;
            r_cmd_addr <= w_rd_ptr;
            r_cmd_req  <= 1'b1;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (cmd_ack) begin
            r_cmd_req <= 1'b0;
            r_state   <= WAIT;
          end
        end
        WAIT: begin
          if (cmd_done) begin
            r_state <= IDLE;
            if (r_cmd_type == CMD_WRITE)
              r_last_wr <= 1'b1;
            else if (r_cmd_type == CMD_READ)
              r_last_wr <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign cmd_req  = r_cmd_req;
  assign cmd_type = r_cmd_type;
  assign cmd_addr = r_cmd_addr;
  assign level    = w_level;
  assign busy     = (r_state != IDLE);
  assign overflow = r_overflow;
  assign ref_miss = r_ref_miss;

endmodule

// File: tb/tb_sdram_stream_scheduler.sv
// ---------------------------------------------------------------------------
// tb_sdram_stream_scheduler
// Bench for sdram_stream_scheduler, built with a 12-bit word address so the
// ring fills and wraps within a short run. Expected behaviour comes from a
// ring-buffer model holding pointers, level, alternation and refresh state.
// ---------------------------------------------------------------------------
module tb_sdram_stream_scheduler;

  localparam int AW     = 12;
  localparam int DEPTH  = 4096;
  localparam int BURST  = 256;
  localparam int URGENT = 768;
  localparam int FAW    = 10;

  localparam int T_WR   = 0;
  localparam int T_RD   = 1;
  localparam int T_REF  = 2;
  localparam int T_NONE = 3;

  logic           CLK48M = 1'b0;
  logic           RESET  = 1'b0;
  logic           enable = 1'b0;
  logic [FAW-1:0] wr_usedw = '0;
  logic           wr_full  = 1'b0;
  logic [FAW-1:0] rd_free  = '0;
  logic           ref_req  = 1'b0;
  logic           cmd_req;
  logic [1:0]     cmd_type;
  logic [AW-1:0]  cmd_addr;
  logic           cmd_ack  = 1'b0;
  logic           cmd_done = 1'b0;
  logic [AW:0]    level;
  logic           busy;
  logic           overflow;
  logic           ref_miss;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_wr, m_rd, m_level, m_last_wr, m_ref_pend, m_ref_miss;

  always #5 CLK48M = ~CLK48M;

  sdram_stream_scheduler #(
    .ADDR_W    (AW),
    .BURST     (BURST),
    .FIFO_AW   (FAW),
    .WR_URGENT (URGENT)
  ) dut (
    .CLK48M   (CLK48M),
    .RESET    (RESET),
    .enable   (enable),
    .wr_usedw (wr_usedw),
    .wr_full  (wr_full),
    .rd_free  (rd_free),
    .ref_req  (ref_req),
    .cmd_req  (cmd_req),
    .cmd_type (cmd_type),
    .cmd_addr (cmd_addr),
    .cmd_ack  (cmd_ack),
    .cmd_done (cmd_done),
    .level    (level),
    .busy     (busy),
    .overflow (overflow),
    .ref_miss (ref_miss)
  );

  // ---------------- model ----------------
  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_level = 0; m_last_wr = 0; m_ref_pend = 0; m_ref_miss = 0;
  endtask

  task automatic model_commit(input int t);
    if (t == T_WR) begin
      m_wr = (m_wr + BURST) % DEPTH; m_level = m_level + BURST; m_last_wr = 1;
    end else if (t == T_RD) begin
      m_rd = (m_rd + BURST) % DEPTH; m_level = m_level - BURST; m_last_wr = 0;
    end
  endtask

  function automatic int predict(input int en, input int uw, input int fr);
    int w_ok, r_ok;
    if (m_ref_pend != 0) return T_REF;
    w_ok = (en != 0) && (uw >= BURST) && (m_level + BURST <= DEPTH);
    r_ok = (m_level >= BURST) && (fr >= BURST);
    if (w_ok && uw >= URGENT) return T_WR;
    if (w_ok && r_ok) return (m_last_wr != 0) ? T_RD : T_WR;
    if (w_ok) return T_WR;
    if (r_ok) return T_RD;
    return T_NONE;
  endfunction

  function automatic logic [AW-1:0] addr_of(input int t);
    if (t == T_WR) return AW'(m_wr);
    if (t == T_RD) return AW'(m_rd);
    return '0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge CLK48M);
  endtask

  task automatic set_in(input int en, input int uw, input int fr);
    enable   = (en != 0);
    wr_usedw = FAW'(uw);
    rd_free  = FAW'(fr);
  endtask

  // Accept the pending command, complete it, and leave inputs quiet so the
  // scheduler sits in IDLE until the caller applies new levels.
  task automatic handshake();
    cmd_ack = 1'b1;
    tick();
    cmd_ack  = 1'b0;
    cmd_done = 1'b1;
    set_in(0, 0, 0);
    tick();
    cmd_done = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RESET = 1'b0;
    set_in(0, 0, 0);
    tick(); tick();
    model_reset();
    n_checks++; if (cmd_req !== 1'b0) begin n_errors++; $display("FAIL reset_cmd_req got %0b want 0", cmd_req); end
    n_checks++; if (cmd_type !== 2'd0) begin n_errors++; $display("FAIL reset_cmd_type got %0d want 0", cmd_type); end
    n_checks++; if (cmd_addr !== '0) begin n_errors++; $display("FAIL reset_cmd_addr got %0d want 0", cmd_addr); end
    n_checks++; if (level !== '0) begin n_errors++; $display("FAIL reset_level got %0d want 0", level); end
    n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (overflow !== 1'b0) begin n_errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
    n_checks++; if (ref_miss !== 1'b0) begin n_errors++; $display("FAIL reset_ref_miss got %0b want 0", ref_miss); end
    RESET = 1'b1;
    tick();
  endtask

  task automatic test_first_write();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 256, 0);
      tick();
      n_checks++;
      if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== AW'(i * BURST)) begin
        n_errors++;
        $display("FAIL first_write%0d req=%0b type=%0d addr=%0d want req=1 type=0 addr=%0d",
                 i, cmd_req, cmd_type, cmd_addr, i * BURST);
      end
      if (i == 0) begin
        tick(); tick();
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== '0 || busy !== 1'b1) begin
          n_errors++;
          $display("FAIL issue_hold req=%0b type=%0d addr=%0d busy=%0b want 1/0/0/1",
                   cmd_req, cmd_type, cmd_addr, busy);
        end
      end
      handshake();
      model_commit(T_WR);
      n_checks++;
      if (level !== (AW+1)'(m_level) || busy !== 1'b0) begin
        n_errors++;
        $display("FAIL first_write_level%0d level=%0d busy=%0b want %0d/0", i, level, busy, m_level);
      end
    end
  endtask

  task automatic test_alternate();
    int uw_tab [4] = '{300, 300, 800, 800};
    int ty_tab [4] = '{T_RD, T_WR, T_WR, T_WR};
    logic [AW-1:0] ea;
    for (int i = 0; i < 4; i++) begin
      set_in(1, uw_tab[i], 1023);
      tick();
      ea = addr_of(ty_tab[i]);
      n_checks++;
      if (cmd_req !== 1'b1 || cmd_type !== 2'(ty_tab[i]) || cmd_addr !== ea) begin
        n_errors++;
        $display("FAIL alternate%0d req=%0b type=%0d addr=%0d want req=1 type=%0d addr=%0d",
                 i, cmd_req, cmd_type, cmd_addr, ty_tab[i], ea);
      end
      handshake();
      model_commit(ty_tab[i]);
      n_checks++;
      if (level !== (AW+1)'(m_level)) begin
        n_errors++; $display("FAIL alternate_level%0d got %0d want %0d", i, level, m_level);
      end
    end
  endtask

  task automatic test_refresh();
    set_in(1, 256, 0);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== AW'(m_wr)) begin
      n_errors++; $display("FAIL ref_pre_write req=%0b type=%0d addr=%0d want 1/0/%0d", cmd_req, cmd_type, cmd_addr, m_wr);
    end
    cmd_ack = 1'b1; set_in(0, 0, 0);
    tick();
    cmd_ack = 1'b0; ref_req = 1'b1;
    tick();
    ref_req = 1'b0; m_ref_pend = 1;
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    model_commit(T_WR);
    set_in(1, 256, 1023);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd2 || cmd_addr !== '0 || ref_miss !== 1'b0) begin
      n_errors++; $display("FAIL ref_issue req=%0b type=%0d addr=%0d miss=%0b want 1/2/0/0", cmd_req, cmd_type, cmd_addr, ref_miss);
    end
    // Second request arriving with the acceptance: flags a miss, stays pending.
    cmd_ack = 1'b1; ref_req = 1'b1; set_in(0, 0, 0);
    tick();
    cmd_ack = 1'b0; ref_req = 1'b0; m_ref_miss = 1;
    n_checks++;
    if (ref_miss !== 1'b1) begin n_errors++; $display("FAIL ref_miss got %0b want 1", ref_miss); end
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd2 || cmd_addr !== '0) begin
      n_errors++; $display("FAIL ref_again req=%0b type=%0d addr=%0d want 1/2/0", cmd_req, cmd_type, cmd_addr);
    end
    m_ref_pend = 0;
    handshake();
    tick();
    n_checks++;
    if (cmd_req !== 1'b0 || ref_miss !== 1'b1 || level !== (AW+1)'(m_level)) begin
      n_errors++; $display("FAIL ref_settle req=%0b miss=%0b level=%0d want 0/1/%0d", cmd_req, ref_miss, level, m_level);
    end
  endtask

  task automatic test_wrap_full();
    int saw_wrap = 0;
    for (int i = 0; i < 20 && m_level < DEPTH; i++) begin
      set_in(1, 1023, 0);
      tick();
      if (m_wr == 0) saw_wrap = 1;
      n_checks++;
      if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== AW'(m_wr)) begin
        n_errors++; $display("FAIL fill%0d req=%0b type=%0d addr=%0d want 1/0/%0d", i, cmd_req, cmd_type, cmd_addr, m_wr);
      end
      handshake();
      model_commit(T_WR);
      n_checks++;
      if (level !== (AW+1)'(m_level)) begin
        n_errors++; $display("FAIL fill_level%0d got %0d want %0d", i, level, m_level);
      end
    end
    n_checks++;
    if (saw_wrap == 0) begin n_errors++; $display("FAIL wrap_seen got 0 want 1"); end
    set_in(1, 1023, 0);
    tick(); tick(); tick();
    n_checks++;
    if (cmd_req !== 1'b0 || level !== (AW+1)'(DEPTH)) begin
      n_errors++; $display("FAIL full_block req=%0b level=%0d want 0/%0d", cmd_req, level, DEPTH);
    end
    n_checks++;
    if (overflow !== 1'b0) begin n_errors++; $display("FAIL overflow_pre got %0b want 0", overflow); end
    wr_full = 1'b1;
    tick();
    wr_full = 1'b0;
    tick();
    n_checks++;
    if (overflow !== 1'b1) begin n_errors++; $display("FAIL overflow_sticky got %0b want 1", overflow); end
    set_in(0, 0, 0);
    tick();
  endtask

  task automatic test_drain();
    cmd_done = 1'b1; cmd_ack = 1'b1;
    tick();
    cmd_done = 1'b0; cmd_ack = 1'b0;
    tick();
    n_checks++;
    if (level !== (AW+1)'(m_level) || busy !== 1'b0 || cmd_req !== 1'b0) begin
      n_errors++; $display("FAIL stray_pulses level=%0d busy=%0b req=%0b want %0d/0/0", level, busy, cmd_req, m_level);
    end
    set_in(0, 0, 1023);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd1 || cmd_addr !== AW'(m_rd)) begin
      n_errors++; $display("FAIL drain_first req=%0b type=%0d addr=%0d want 1/1/%0d", cmd_req, cmd_type, cmd_addr, m_rd);
    end
    handshake();
    model_commit(T_RD);
    set_in(1, 256, 0);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== AW'(m_wr)) begin
      n_errors++; $display("FAIL en_fall_write req=%0b type=%0d addr=%0d want 1/0/%0d", cmd_req, cmd_type, cmd_addr, m_wr);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0; enable = 1'b0;
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    model_commit(T_WR);
    n_checks++;
    if (level !== (AW+1)'(m_level)) begin
      n_errors++; $display("FAIL en_fall_level got %0d want %0d", level, m_level);
    end
    for (int i = 0; i < 20 && m_level >= BURST; i++) begin
      set_in(0, 1023, 1023);
      tick();
      n_checks++;
      if (cmd_req !== 1'b1 || cmd_type !== 2'd1 || cmd_addr !== AW'(m_rd)) begin
        n_errors++; $display("FAIL drain%0d req=%0b type=%0d addr=%0d want 1/1/%0d", i, cmd_req, cmd_type, cmd_addr, m_rd);
      end
      handshake();
      model_commit(T_RD);
    end
    set_in(0, 1023, 1023);
    tick(); tick(); tick();
    n_checks++;
    if (cmd_req !== 1'b0 || level !== '0) begin
      n_errors++; $display("FAIL drain_end req=%0b level=%0d want 0/0", cmd_req, level);
    end
    set_in(0, 0, 0);
    tick();
  endtask

  task automatic test_async_reset();
    set_in(1, 256, 0);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_addr !== AW'(m_wr)) begin
      n_errors++; $display("FAIL arst_pre req=%0b addr=%0d want 1/%0d", cmd_req, cmd_addr, m_wr);
    end
    #2 RESET = 1'b0;
    #1;
    n_checks++;
    if (cmd_req !== 1'b0 || busy !== 1'b0 || level !== '0 || overflow !== 1'b0 || ref_miss !== 1'b0) begin
      n_errors++; $display("FAIL arst_async req=%0b busy=%0b level=%0d ovf=%0b miss=%0b want all 0",
                           cmd_req, busy, level, overflow, ref_miss);
    end
    tick();
    RESET = 1'b1;
    set_in(0, 0, 0);
    model_reset();
    tick();
    set_in(1, 256, 0);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd0 || cmd_addr !== '0) begin
      n_errors++; $display("FAIL arst_wr_ptr req=%0b type=%0d addr=%0d want 1/0/0", cmd_req, cmd_type, cmd_addr);
    end
    handshake();
    model_commit(T_WR);
    set_in(0, 0, 1023);
    tick();
    n_checks++;
    if (cmd_req !== 1'b1 || cmd_type !== 2'd1 || cmd_addr !== '0) begin
      n_errors++; $display("FAIL arst_rd_ptr req=%0b type=%0d addr=%0d want 1/1/0", cmd_req, cmd_type, cmd_addr);
    end
    handshake();
    model_commit(T_RD);
  endtask

  task automatic test_random();
    int en, uw, fr, rp, exp_t;
    logic [AW-1:0] ea;
    for (int i = 0; i < 120; i++) begin
      en = ($urandom_range(0, 3) != 0) ? 1 : 0;
      uw = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(200, 320));
      fr = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(200, 320));
      rp = ($urandom_range(0, 9) == 0) ? 1 : 0;
      set_in(en, uw, fr);
      ref_req = (rp != 0);
      // The decision uses the pending flag as it stood before this pulse.
      exp_t = predict(en, uw, fr);
      if (rp != 0) begin
        if (m_ref_pend != 0) m_ref_miss = 1;
        m_ref_pend = 1;
      end
      tick();
      ref_req = 1'b0;
      if (exp_t == T_NONE) begin
        n_checks++;
        if (cmd_req !== 1'b0) begin
          n_errors++; $display("FAIL rand_idle%0d req=%0b want 0 (en=%0d uw=%0d fr=%0d lvl=%0d)", i, cmd_req, en, uw, fr, m_level);
        end
      end else begin
        ea = addr_of(exp_t);
        n_checks++;
        if (cmd_req !== 1'b1 || cmd_type !== 2'(exp_t) || cmd_addr !== ea) begin
          n_errors++; $display("FAIL rand_cmd%0d req=%0b type=%0d addr=%0d want 1/%0d/%0d", i, cmd_req, cmd_type, cmd_addr, exp_t, ea);
        end
        if (exp_t == T_REF) m_ref_pend = 0;
        handshake();
        model_commit(exp_t);
        n_checks++;
        if (level !== (AW+1)'(m_level) || ref_miss !== 1'(m_ref_miss) || busy !== 1'b0) begin
          n_errors++; $display("FAIL rand_state%0d level=%0d miss=%0b busy=%0b want %0d/%0d/0", i, level, ref_miss, busy, m_level, m_ref_miss);
        end
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    test_reset();
    test_first_write();
    test_alternate();
    test_refresh();
    test_wrap_full();
    test_drain();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
